// File: rtl/button_event_pkg.sv
// button_event_pkg: event type codes and per-button FSM encoding shared by the
// button event scheduler.
package button_event_pkg;
  localparam logic [1:0] EVT_NONE    = 2'd0;
  localparam logic [1:0] EVT_PRESS   = 2'd1;
  localparam logic [1:0] EVT_RELEASE = 2'd2;
  localparam logic [1:0] EVT_REPEAT  = 2'd3;
  typedef enum logic [1:0] {ST_IDLE, ST_HELD, ST_REPEAT} btn_state_e;
endpackage

// File: rtl/btn_repeat_fsm.sv
// btn_repeat_fsm: per-button press/release/auto-repeat detector; evt_raise is a
// one-cycle Mealy pulse so the pending slot captures it on the sampling edge.
module btn_repeat_fsm
  import button_event_pkg::*;
#(
  parameter int               CNT_W        = 24,
  parameter logic [CNT_W-1:0] HOLD_TICKS   = CNT_W'(12_500_000),
  parameter logic [CNT_W-1:0] REPEAT_TICKS = CNT_W'(2_500_000)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       level,
  input  logic       repeat_en,
  output logic       evt_raise,
  output logic [1:0] evt_kind
);
  btn_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hold_hit, rep_hit;
  assign hold_hit = cnt_q == HOLD_TICKS - CNT_W'(1);
  assign rep_hit  = cnt_q == REPEAT_TICKS - CNT_W'(1);
  // Release is tested first so it wins over a same-cycle timer expiry.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    evt_raise = 1'b0;
    evt_kind  = EVT_NONE;
    case (state_q)
      ST_IDLE: if (level) begin
        state_d   = ST_HELD;
        cnt_d     = '0;
        evt_raise = 1'b1;
        evt_kind  = EVT_PRESS;
      end
      ST_HELD: if (!level) begin
        state_d   = ST_IDLE;
        evt_raise = 1'b1;
        evt_kind  = EVT_RELEASE;
      end else if (repeat_en && hold_hit) begin
        state_d   = ST_REPEAT;
        cnt_d     = '0;
        evt_raise = 1'b1;
        evt_kind  = EVT_REPEAT;
      end else begin
        cnt_d = hold_hit ? cnt_q : cnt_q + CNT_W'(1);
      end
      ST_REPEAT: if (!level) begin
        state_d   = ST_IDLE;
        evt_raise = 1'b1;
        evt_kind  = EVT_RELEASE;
      end else if (!repeat_en) begin
        state_d = ST_HELD;
        cnt_d   = '0;
      end else if (rep_hit) begin
        cnt_d     = '0;
        evt_raise = 1'b1;
        evt_kind  = EVT_REPEAT;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: rtl/button_event_sched.sv
// button_event_sched: per-button event detectors feeding one-deep pending slots
// that share a single valid/ready event channel through a round-robin arbiter.
module button_event_sched
  import button_event_pkg::*;
#(
  parameter int               NUM_BTN      = 4,
  parameter int               CNT_W        = 24,
  parameter logic [CNT_W-1:0] HOLD_TICKS   = CNT_W'(12_500_000),
  parameter logic [CNT_W-1:0] REPEAT_TICKS = CNT_W'(2_500_000),
  localparam int              ID_W         = (NUM_BTN > 1) ? $clog2(NUM_BTN) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_BTN-1:0] btn_level,
  input  logic               repeat_en,
  output logic               evt_valid,
  input  logic               evt_ready,
  output logic [ID_W-1:0]    evt_id,
  output logic [1:0]         evt_type,
  output logic [NUM_BTN-1:0] overrun,
  input  logic               clr_overrun
);
  logic [NUM_BTN-1:0]      raise, gnt_oh;
  logic [NUM_BTN-1:0][1:0] kind, pend_type_q, pend_type_d;
  logic [NUM_BTN-1:0]      pend_valid_q, pend_valid_d, overrun_q, overrun_d;
  logic [ID_W-1:0]         rr_q, rr_d, gnt_idx, id_q, id_d;
  logic [ID_W:0]           cand;
  logic [1:0]              type_q, type_d;
  logic                    valid_q, valid_d, gnt_found, load, take;
  genvar b;
  for (b = 0; b < NUM_BTN; b++) begin : g_btn
    btn_repeat_fsm #(
      .CNT_W       (CNT_W),
      .HOLD_TICKS  (HOLD_TICKS),
      .REPEAT_TICKS(REPEAT_TICKS)
    ) u_fsm (
      .clk      (clk),
      .rst_n    (rst_n),
      .level    (btn_level[b]),
      .repeat_en(repeat_en),
      .evt_raise(raise[b]),
      .evt_kind (kind[b])
    );
  end
  // First pending slot at or after rr_q, wrapping modulo NUM_BTN.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NUM_BTN; k++) begin
      cand = {1'b0, rr_q} + (ID_W+1)'(k);
      cand = (cand >= (ID_W+1)'(NUM_BTN)) ? cand - (ID_W+1)'(NUM_BTN) : cand;
      if (!gnt_found && pend_valid_q[cand[ID_W-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand[ID_W-1:0];
      end
    end
  end
  assign load   = !valid_q || evt_ready;
  assign take   = load && gnt_found;
  assign gnt_oh = take ? NUM_BTN'(1) << gnt_idx : '0;
  always_comb begin
    pend_valid_d = pend_valid_q;
    pend_type_d  = pend_type_q;
    overrun_d    = clr_overrun ? '0 : overrun_q;
    for (int i = 0; i < NUM_BTN; i++) begin
      if (raise[i]) begin
        overrun_d[i]    = overrun_d[i] | (pend_valid_q[i] & ~gnt_oh[i]);
        pend_valid_d[i] = 1'b1;
        pend_type_d[i]  = kind[i];
      end else if (gnt_oh[i]) begin
        pend_valid_d[i] = 1'b0;
      end
    end
    valid_d = load ? gnt_found : valid_q;
    id_d    = take ? gnt_idx : id_q;
    type_d  = take ? pend_type_q[gnt_idx] : type_q;
    rr_d    = !take ? rr_q : (gnt_idx == ID_W'(NUM_BTN - 1)) ? '0 : gnt_idx + ID_W'(1);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_valid_q <= '0;
      pend_type_q  <= '0;
      overrun_q    <= '0;
      valid_q      <= 1'b0;
      id_q         <= '0;
      type_q       <= EVT_NONE;
      rr_q         <= '0;
    end else begin
      pend_valid_q <= pend_valid_d;
      pend_type_q  <= pend_type_d;
      overrun_q    <= overrun_d;
      valid_q      <= valid_d;
      id_q         <= id_d;
      type_q       <= type_d;
      rr_q         <= rr_d;
    end
  end
  assign evt_valid = valid_q;
  assign evt_id    = id_q;
  assign evt_type  = type_q;
  assign overrun   = overrun_q;
endmodule

// File: tb/tb_button_event_sched.sv
// tb_button_event_sched: directed scenarios plus random stimulus, compared each
// cycle against a timestamp-based behavioural model of the event scheduler.
module tb_button_event_sched;
  import button_event_pkg::*;
  localparam int N = 4, HOLD = 8, REP = 4;
  logic         clk = 1'b0, rst_n = 1'b0;
  logic [N-1:0] btn_level = '0;
  logic         repeat_en = 1'b0, evt_ready = 1'b1, clr_overrun = 1'b0;
  logic         evt_valid;
  logic [1:0]   evt_id, evt_type;
  logic [N-1:0] overrun;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  button_event_sched #(
    .NUM_BTN(N), .CNT_W(24), .HOLD_TICKS(24'(HOLD)), .REPEAT_TICKS(24'(REP))
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn_level(btn_level), .repeat_en(repeat_en),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_id(evt_id),
    .evt_type(evt_type), .overrun(overrun), .clr_overrun(clr_overrun)
  );
  // Model: each button is idle/held/repeating with an absolute due time for its next REPEAT.
  int         m_mode[N], m_due[N], m_rr, m_id, now;
  bit         m_pv[N], m_valid;
  logic [1:0] m_pt[N], m_type;
  logic [N-1:0] m_ov;
  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_mode[i] = 0; m_due[i] = 0; m_pv[i] = 0; m_pt[i] = 0;
    end
    m_ov = '0; m_rr = 0; m_valid = 0; m_id = 0; m_type = 0; now = 0;
  endtask
  task automatic model_step();
    bit load, found, g;
    int gi;
    bit r[N];
    logic [1:0] kd[N];
    now++;
    load = !m_valid || evt_ready;
    found = 0; gi = 0;
    for (int k = 0; k < N; k++) begin
      int j = (m_rr + k) % N;
      if (!found && m_pv[j]) begin found = 1; gi = j; end
    end
    for (int i = 0; i < N; i++) begin
      r[i] = 0; kd[i] = EVT_NONE;
      if (m_mode[i] == 0) begin
        if (btn_level[i]) begin m_mode[i] = 1; m_due[i] = now + HOLD; r[i] = 1; kd[i] = EVT_PRESS; end
      end else if (!btn_level[i]) begin
        m_mode[i] = 0; r[i] = 1; kd[i] = EVT_RELEASE;
      end else if (m_mode[i] == 1) begin
        if (repeat_en && now >= m_due[i]) begin m_mode[i] = 2; m_due[i] = now + REP; r[i] = 1; kd[i] = EVT_REPEAT; end
      end else if (!repeat_en) begin
        m_mode[i] = 1; m_due[i] = now + HOLD;
      end else if (now >= m_due[i]) begin
        m_due[i] = now + REP; r[i] = 1; kd[i] = EVT_REPEAT;
      end
    end
    if (load) begin
      m_valid = found;
      if (found) begin m_id = gi; m_type = m_pt[gi]; m_rr = (gi + 1) % N; end
    end
    if (clr_overrun) m_ov = '0;
    for (int i = 0; i < N; i++) begin
      g = load && found && gi == i;
      if (r[i]) begin
        if (m_pv[i] && !g) m_ov[i] = 1'b1;
        m_pv[i] = 1; m_pt[i] = kd[i];
      end else if (g) begin
        m_pv[i] = 0;
      end
    end
  endtask
  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end
  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        check("model.valid", int'(evt_valid), int'(m_valid));
        if (m_valid && evt_valid) begin
          check("model.id", int'(evt_id), m_id);
          check("model.type", int'(evt_type), int'(m_type));
        end
        check("model.overrun", int'(overrun), int'(m_ov));
      end
    end
  end
  task automatic expect_out(input string nm, input bit v, input int id, input int ty);
    check({nm, ".valid"}, int'(evt_valid), int'(v));
    if (v) begin
      check({nm, ".id"}, int'(evt_id), id);
      check({nm, ".type"}, int'(evt_type), ty);
    end
  endtask
  task automatic do_reset();
    @(negedge clk); rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask
  task automatic hold_btn2(input logic en, output int reps, output int prs, output int rels);
    reps = 0; prs = 0; rels = 0;
    @(negedge clk); repeat_en = en; btn_level = 4'b0100;
    for (int c = 0; c < 26; c++) begin
      @(negedge clk);
      if (evt_valid && evt_id == 2'd2) begin
        reps += (evt_type == EVT_REPEAT) ? 1 : 0;
        prs  += (evt_type == EVT_PRESS) ? 1 : 0;
        rels += (evt_type == EVT_RELEASE) ? 1 : 0;
      end
      if (c == 19) btn_level = '0;
    end
  endtask
  int reps, prs, rels;
  int order[4];
  initial begin
    repeat (2) @(negedge clk);
    expect_out("reset", 0, 0, 0);
    check("reset.id", int'(evt_id), 0);
    check("reset.type", int'(evt_type), 0);
    check("reset.overrun", int'(overrun), 0);
    rst_n = 1'b1;
    // single press / release on button 1
    @(negedge clk); btn_level = 4'b0010;
    @(negedge clk); expect_out("t1.latency", 0, 0, 0);
    @(negedge clk); expect_out("t1.press", 1, 1, EVT_PRESS); btn_level = '0;
    @(negedge clk); expect_out("t1.once", 0, 0, 0);
    @(negedge clk); expect_out("t1.release", 1, 1, EVT_RELEASE);
    repeat (2) @(negedge clk);
    // hold with and without auto-repeat
    hold_btn2(1'b1, reps, prs, rels);
    check("t2.repeats", reps, 3); check("t2.press", prs, 1); check("t2.release", rels, 1);
    hold_btn2(1'b0, reps, prs, rels);
    check("t2.norep.repeats", reps, 0); check("t2.norep.press", prs, 1); check("t2.norep.release", rels, 1);
    // simultaneous presses, round-robin order from pointer 0 and pointer 2
    do_reset();
    @(negedge clk); btn_level = 4'b1111;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin @(negedge clk); expect_out("t3.rr0", 1, i, EVT_PRESS); end
    btn_level = '0;
    repeat (6) @(negedge clk);
    btn_level = 4'b0010;
    repeat (3) @(negedge clk);
    btn_level = '0;
    repeat (4) @(negedge clk);
    btn_level = 4'b1111;
    @(negedge clk);
    order = '{2, 3, 0, 1};
    for (int i = 0; i < 4; i++) begin @(negedge clk); expect_out("t3.rr2", 1, order[i], EVT_PRESS); end
    btn_level = '0;
    repeat (6) @(negedge clk);
    // backpressure, pending queueing and overrun
    evt_ready = 1'b0; btn_level = 4'b0001;
    @(negedge clk);
    @(negedge clk); expect_out("t4.press", 1, 0, EVT_PRESS); btn_level = '0;
    @(negedge clk); expect_out("t4.stall", 1, 0, EVT_PRESS); check("t4.no_overrun", int'(overrun), 0); btn_level = 4'b0001;
    @(negedge clk); expect_out("t4.stall2", 1, 0, EVT_PRESS); check("t4.overrun", int'(overrun), 1); clr_overrun = 1'b1;
    @(negedge clk); clr_overrun = 1'b0; check("t4.cleared", int'(overrun), 0);
    evt_ready = 1'b1; btn_level = '0;
    repeat (6) @(negedge clk);
    // asynchronous reset while an event is presented
    evt_ready = 1'b0; btn_level = 4'b1000;
    repeat (2) @(negedge clk); expect_out("t5.pre", 1, 3, EVT_PRESS);
    @(posedge clk); #2 rst_n = 1'b0;
    #1 check("t5.async_drop", int'(evt_valid), 0);
    @(negedge clk); evt_ready = 1'b1;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); expect_out("t5.latency", 0, 0, 0);
    @(negedge clk); expect_out("t5.press", 1, 3, EVT_PRESS);
    @(negedge clk); expect_out("t5.once", 0, 0, 0);
    btn_level = '0;
    repeat (4) @(negedge clk);
    // random traffic against the model
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) if ($urandom_range(0, 13) == 0) btn_level[i] = ~btn_level[i];
      if ($urandom_range(0, 39) == 0) repeat_en = ~repeat_en;
      evt_ready   = $urandom_range(0, 3) != 0;
      clr_overrun = $urandom_range(0, 29) == 0;
    end
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/button_event_sched.md
Name: button_event_sched

Overview:
- Sits between the per-button debouncers and the GPU command/register logic.
- Turns each debounced button level into discrete PRESS, RELEASE and auto-REPEAT events, using one hold/repeat timer per button.
- Shares one valid/ready event channel between all buttons through a round-robin arbiter.
- Downstream logic therefore consumes one event at a time and never polls the raw button levels.

Parameters:
- NUM_BTN, 4: number of debounced button inputs (1 to 8).
- CNT_W, 24: width of each per-button hold/repeat counter.
- HOLD_TICKS, 24'd12_500_000: cycles a button must be held before the first REPEAT (0.5 s at 25 MHz).
- REPEAT_TICKS, 24'd2_500_000: cycles between successive REPEAT events (0.1 s at 25 MHz).
- ID_W, derived: $clog2(NUM_BTN), minimum 1. Not user-set.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous assert, active-low; all state clears immediately.
- btn_level  in  NUM_BTN  debounced button levels; 1 = pressed.
- repeat_en  in  1  global auto-repeat enable.
- evt_valid  out  1  event available.
- evt_ready  in  1  consumer accepts the event.
- evt_id  out  ID_W  index of the button that produced the event.
- evt_type  out  2  1 = PRESS, 2 = RELEASE, 3 = REPEAT. 0 is never emitted.
- overrun  out  NUM_BTN  sticky flag per button: a pending event was overwritten.
- clr_overrun  in  1  single-cycle pulse; clears all overrun bits.

Behaviour:
Reset values:
- evt_valid=0, evt_id=0, evt_type=0, overrun=0.
- All button FSMs in IDLE; counters 0; pending flags 0; round-robin pointer 0.

Per-button FSM (one per button; prev_level register, counter):
- IDLE: level 1 -> HELD, counter=0, raise PRESS.
- HELD: level 0 -> IDLE, raise RELEASE.
- HELD: repeat_en=1 and counter==HOLD_TICKS-1 -> REPEAT, counter=0, raise REPEAT.
- HELD, otherwise: counter increments, saturating at HOLD_TICKS-1.
- REPEAT: level 0 -> IDLE, raise RELEASE.
- REPEAT: repeat_en=0 -> HELD, counter=0, no event.
- REPEAT: counter==REPEAT_TICKS-1 -> counter=0, raise REPEAT.
- REPEAT, otherwise: counter increments.
- Release takes priority over a timer expiry in the same cycle.

Pending slot (one per button):
- A raised event writes pend_valid[i]=1 and pend_type[i].
- If pend_valid[i] is already 1 and the slot is not granted this cycle: the new event overwrites the slot and overrun[i] sets.
- If the slot is granted in the same cycle a new event is raised: the new event becomes pending, and overrun does not set.
- clr_overrun coinciding with a new overrun: the set wins.

Arbiter / output register:
- The output register may load when evt_valid=0 or (evt_valid && evt_ready).
- Grant goes to the first pend_valid at or after rr_ptr, searching upward with modulo wrap.
- On grant: load evt_id and evt_type, clear that pending slot, set rr_ptr = granted index + 1 (wraps to 0).
- No pending slots: evt_valid drops after a handshake.
- While evt_valid=1 and evt_ready=0: evt_id and evt_type hold stable.
- Back-to-back handshakes sustain one event per cycle.
- Latency: a level change sampled at edge N gives evt_valid high after edge N+1, provided the output is free.

Boundary conditions:
- NUM_BTN=1: rr_ptr is constant 0.
- Counter compare uses CNT_W-bit equality; HOLD_TICKS and REPEAT_TICKS must each be at least 2.
- Reset asserted mid-handshake: evt_valid drops asynchronously and pending events are discarded.
- After reset release, buttons already held generate PRESS (prev state IDLE).

Decomposition:
- Package button_event_pkg holds:
  - the event type constants EVT_NONE, EVT_PRESS, EVT_RELEASE, EVT_REPEAT (2 bits);
  - the FSM state encoding ST_IDLE, ST_HELD, ST_REPEAT.
- Sub-module btn_repeat_fsm: one instance per button via generate. It holds the FSM and counter and outputs a one-cycle evt_raise plus evt_kind.
- The top module owns the pending slots, overrun flags, round-robin arbiter and output register.

Test Plan:
Bench configuration: NUM_BTN=4, HOLD_TICKS=8, REPEAT_TICKS=4, evt_ready=1 unless stated.
1. btn_level 0000->0010 -> next cycle evt_valid=1, evt_id=1, evt_type=1, for exactly one cycle. Drop to 0000 -> evt_id=1, evt_type=2.
2. Hold btn 2 for 20 cycles with repeat_en=1 -> PRESS, then REPEAT 8 cycles after the press, then REPEATs every 4 cycles, then RELEASE on drop. With repeat_en=0: only PRESS and RELEASE.
3. btn_level 0000->1111 in one cycle -> four back-to-back events with ids 0,1,2,3, all PRESS. Repeat with rr_ptr at 2 -> order 2,3,0,1.
4. evt_ready=0 while btn 0 presses then releases -> evt_valid holds PRESS (id 0) stable. The RELEASE overwrites nothing; it queues in the pending slot. A subsequent press then sets overrun[0]=1. clr_overrun -> overrun=0.
5. Assert rst_n=0 asynchronously mid-cycle with evt_valid=1 -> evt_valid=0 before the next clk edge. After release with btn 3 held -> one PRESS, id 3.
